seq_detect_sched: RTL and testbench

//  Round-robin scheduler that shares one serial Moore pattern detector among N_REQ requesters.
//  - Grants one requester at a time and latches its DATA_W-bit word.
//  - Clears the detector, shifts the word in MSB-first on det_x, and samples det_y after every bit.
//  - Returns the match count, and the id of the requester it belongs to, with a one-cycle done pulse.
//  - Sits between the requesters and the detector; it is the only driver of det_x and det_rst.

---
 rtl/seq_detect_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_seq_detect_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that time-shares one serial Moore detector among N_REQ requesters.
// Define SEQ_SCHED_FIRST_HIT_EN to add the first_hit output (index of the first high det_y sample).
module seq_detect_sched #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic [ID_W-1:0]         done_id,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    match_any,
`ifdef SEQ_SCHED_FIRST_HIT_EN
  output logic [CNT_W-1:0]        first_hit,
`endif
  output logic                    det_x,
  output logic                    det_rst,
  input  logic                    det_y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic                match_any_q, match_any_d;
  logic                found_s;
  logic [ID_W-1:0]     pick_s;
  logic [ID_W-1:0]     cand_s;
  logic                sample_s;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  localparam logic [CNT_W-1:0] NO_HIT = CNT_W'(DATA_W);
  logic [CNT_W-1:0]    fh_q, fh_d;
  logic [CNT_W-1:0]    first_hit_q, first_hit_d;
  logic [CNT_W-1:0]    sample_idx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (bit_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    det_x   = 1'b0;
    det_rst = ~rst_n;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_CLR: begin
        gnt     = N_REQ'(1) << cur_id_q;
        busy    = 1'b1;
        det_rst = 1'b1;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        det_x = shreg_q[DATA_W-1];
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Search starts one past the last granted id and wraps, so requester rr_ptr+1 wins ties.
  always_comb begin
    found_s = 1'b0;
    pick_s  = rr_ptr_q;
    cand_s  = rr_ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // det_y lags det_x by one cycle, so the first SHIFT cycle has nothing to sample yet.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    match_any_d = match_any_q;
    sample_s    = ((state_q == S_SHIFT) && (bit_idx_q != '0)) || (state_q == S_DRAIN);
`ifdef SEQ_SCHED_FIRST_HIT_EN
    fh_d         = fh_q;
    first_hit_d  = first_hit_q;
    sample_idx_s = (state_q == S_DRAIN) ? LAST_IDX : (bit_idx_q - CNT_W'(1));
`endif
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          cur_id_d = pick_s;
          rr_ptr_d = pick_s;
          shreg_d  = req_data[int'(pick_s)*DATA_W +: DATA_W];
        end else begin
          cur_id_d = cur_id_q;
        end
      end
      S_CLR: begin
        cnt_d     = '0;
        bit_idx_d = '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
        fh_d      = NO_HIT;
`endif
      end
      S_SHIFT: begin
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        bit_idx_d = bit_idx_q + CNT_W'(1);
      end
      S_DRAIN: begin
        shreg_d = shreg_q;
      end
      S_DONE: begin
        shreg_d = shreg_q;
      end
      default: begin
        shreg_d = shreg_q;
      end
    endcase

    if (sample_s && det_y) begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_SCHED_FIRST_HIT_EN
      if (fh_q == NO_HIT) begin
        fh_d = sample_idx_s;
      end else begin
        fh_d = fh_q;
      end
`endif
    end else begin
      cnt_d = cnt_d;
    end

    // Results land on the DRAIN->DONE edge so they are valid alongside the done pulse.
    if (state_q == S_DRAIN) begin
      match_cnt_d = cnt_d;
      match_any_d = (cnt_d != '0);
      done_id_d   = cur_id_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
      first_hit_d = fh_d;
`endif
    end else begin
      match_cnt_d = match_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      cur_id_q    <= '0;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
      match_any_q <= 1'b0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
      fh_q        <= '0;
      first_hit_q <= '0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      match_any_q <= match_any_d;
`ifdef SEQ_SCHED_FIRST_HIT_EN
      fh_q        <= fh_d;
      first_hit_q <= first_hit_d;
`endif
    end
  end

  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign match_any = match_any_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  assign first_hit = first_hit_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched with a "three equal bits in a row" Moore detector attached.
module tb_seq_detect_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0000_0000;
  logic [3:0]  gnt;
  logic        busy, done, match_any, det_x, det_rst, det_y;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  logic [3:0]  first_hit;
`endif

  logic        d_last = 1'b0;
  logic [1:0]  d_run = 2'd0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          gnt_cyc = 0;
  int          prev_gnt = 0;

  seq_detect_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .match_any (match_any),
`ifdef SEQ_SCHED_FIRST_HIT_EN
    .first_hit (first_hit),
`endif
    .det_x     (det_x),
    .det_rst   (det_rst),
    .det_y     (det_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Detector: run length of the current bit value, saturating at 3; output high at 3.
  always @(posedge clk) begin
    if (det_rst) begin
      d_last <= 1'b0;
      d_run  <= 2'd0;
    end else if (d_run == 2'd0 || det_x != d_last) begin
      d_last <= det_x;
      d_run  <= 2'd1;
    end else if (d_run != 2'd3) begin
      d_run  <= d_run + 2'd1;
    end
  end
  assign det_y = (d_run == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the grant, then follows the word through to its done cycle.
  task automatic run_word(input int id, input logic [7:0] word, input int exp_cnt,
                          input int exp_fh, input bit drop);
    int t;
    t = 0;
    while (gnt === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("gnt", gnt, 32'd1 << id);
    chk("busy_clr", busy, 32'd1);
    chk("det_rst_clr", det_rst, 32'd1);
    prev_gnt = gnt_cyc;
    gnt_cyc  = cyc;
    if (drop) begin
      req[id] = 1'b0;
      req_data[id*8 +: 8] = ~word;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8) chk("det_x", det_x, word[8-k]);
      else if (k == 9) chk("det_x_drain", det_x, 32'd0);
      chk("done", done, (k == 10) ? 32'd1 : 32'd0);
    end
    chk("done_id", done_id, id);
    chk("match_cnt", match_cnt, exp_cnt);
    chk("match_any", match_any, (exp_cnt != 0) ? 32'd1 : 32'd0);
`ifdef SEQ_SCHED_FIRST_HIT_EN
    chk("first_hit", first_hit, exp_fh);
`endif
    if (exp_fh < 0) $display("note: negative first-hit expectation for id %0d", id);
  endtask

  initial begin
    int t;
    // 1. Reset held three cycles, then released idle.
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_done_id", done_id, 32'd0);
    chk("rst_match_cnt", match_cnt, 32'd0);
    chk("rst_match_any", match_any, 32'd0);
    chk("rst_det_x", det_x, 32'd0);
    chk("rst_det_rst", det_rst, 32'd1);
`ifdef SEQ_SCHED_FIRST_HIT_EN
    chk("rst_first_hit", first_hit, 32'd0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 32'd0);
      chk("idle_det_rst", det_rst, 32'd0);
    end

    // 2. Requester 0, 0xFF.
    req_data[7:0] = 8'hFF;
    req = 4'b0001;
    run_word(0, 8'hFF, 6, 2, 1'b1);
    @(negedge clk);
    chk("done_pulse_width", done, 32'd0);
    chk("held_match_cnt", match_cnt, 32'd6);
    chk("held_done_id", done_id, 32'd0);

    // 3. Requester 2, 0xE3 then 0xAA.
    req_data[23:16] = 8'hE3;
    req[2] = 1'b1;
    run_word(2, 8'hE3, 2, 2, 1'b1);
    req_data[23:16] = 8'hAA;
    req[2] = 1'b1;
    run_word(2, 8'hAA, 0, 8, 1'b1);

    // 4. req=0101 from reset, held: grants 0,2,0,2 at 12-cycle spacing.
    @(negedge clk);
    rst_n = 1'b0;
    req_data[7:0]   = 8'hFF;
    req_data[23:16] = 8'hE3;
    req = 4'b0101;
    #1;
    chk("rst4_det_rst", det_rst, 32'd1);
    repeat (2) @(negedge clk);
    chk("rst4_busy", busy, 32'd0);
    rst_n = 1'b1;
    run_word(0, 8'hFF, 6, 2, 1'b0);
    run_word(2, 8'hE3, 2, 2, 1'b0);
    chk("gap_0_2", gnt_cyc - prev_gnt, 32'd12);
    run_word(0, 8'hFF, 6, 2, 1'b0);
    chk("gap_2_0", gnt_cyc - prev_gnt, 32'd12);
    run_word(2, 8'hE3, 2, 2, 1'b0);
    chk("gap_0_2b", gnt_cyc - prev_gnt, 32'd12);

    // 5. Requester 1 word 0x00, reset during the 5th SHIFT cycle.
    req = 4'b0010;
    req_data[15:8] = 8'h00;
    t = 0;
    while (gnt === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("abort_gnt", gnt, 32'd2);
    repeat (5) @(negedge clk);
    chk("abort_busy_pre", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_det_rst", det_rst, 32'd1);
    chk("abort_busy", busy, 32'd0);
    chk("abort_det_x", det_x, 32'd0);
    chk("abort_done", done, 32'd0);
    chk("abort_match_cnt", match_cnt, 32'd0);
    @(negedge clk);
    chk("abort_done2", done, 32'd0);
    rst_n = 1'b1;
    chk("abort_idle", busy, 32'd0);
    run_word(1, 8'h00, 6, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
